ts_ep_packer: RTL and testbench

Parametrised TS ingress/egress block between the demod/TSGEN/USB-OUT byte sources and the USB IN endpoint buffer. It selects one of NSRC byte-wide TS sources and admits only whole, sync-aligned 188-byte packets into an internal FIFO, dropping whole packets rather than partial ones. It drains the FIFO into the endpoint buffer with a commit/ack handshake. New over the previous generation: packet-aligned admission, sync-loss recovery, a timed partial-commit flush, and saturating statistics.

---
 rtl/ts_ep_packer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ts_ep_packer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_ep_packer.sv
// ts_ep_packer
// Selects one of NSRC byte-wide TS sources, admits only whole sync-aligned
// 188-byte packets into an internal byte FIFO, and drains the FIFO into a USB
// IN endpoint buffer with a commit/ack handshake.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   sel               source select (>= NSRC selects nothing)
//   src_data/valid    NSRC byte lanes, lane i at [8i+7:8i], per-lane strobe
//   commit_len        bytes per full commit (0 behaves as 1)
//   flush_en          allow a timed partial commit when ingress goes quiet
//   src_almost_full   FIFO free space below one packet
//   ep_addr/data/wren endpoint buffer write port
//   ep_commit(_len)   commit request and its byte count, held until ack/timeout
//   ep_ready          endpoint can accept writes
//   ep_commit_ack     asynchronous commit acknowledge
//   *_cnt             saturating statistics
//   fifo_level        FIFO occupancy in bytes
module ts_ep_packer #(
  parameter int NSRC      = 4,
  parameter int SEL_W     = 2,
  parameter int FIFO_AW   = 11,
  parameter int EP_AW     = 11,
  parameter int ACK_TMO   = 64,
  parameter int FLUSH_TMO = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NSRC*8-1:0]    src_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [EP_AW-1:0]     commit_len,
  input  logic                 flush_en,
  output logic                 src_almost_full,
  output logic [EP_AW-1:0]     ep_addr,
  output logic [7:0]           ep_data,
  output logic                 ep_wren,
  output logic                 ep_commit,
  output logic [EP_AW-1:0]     ep_commit_len,
  input  logic                 ep_ready,
  input  logic                 ep_commit_ack,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          sync_err_cnt,
  output logic [15:0]          ack_miss_cnt,
  output logic [15:0]          commit_cnt,
  output logic [FIFO_AW:0]     fifo_level
);
  localparam int FT_W = $clog2(FLUSH_TMO + 1);
  localparam int AT_W = $clog2(ACK_TMO + 1);
  localparam logic [7:0]       SYNC    = 8'h47;
  localparam logic [7:0]       BC_LAST = 8'd187;
  localparam logic [FIFO_AW:0] DEPTH_V = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] PKT_V   = (FIFO_AW+1)'(188);
  localparam logic [FT_W-1:0]  FT_MAX  = FT_W'(FLUSH_TMO - 1);
  localparam logic [AT_W-1:0]  AT_MAX  = AT_W'(ACK_TMO - 1);

  typedef enum logic [1:0] {I_HUNT, I_PASS, I_DROP} ist_t;
  typedef enum logic [1:0] {E_IDLE, E_READ, E_WRITE, E_WAIT} est_t;

  ist_t ist_q, ist_d;
  est_t est_q, est_d;

  logic [SEL_W-1:0] src_q, src_d, src_idx;
  logic [7:0]       bc_q, bc_d;
  logic [7:0]       in_byte;
  logic             in_vld;

  logic [7:0]       mem [1<<FIFO_AW];
  logic [7:0]       rdata_q;
  logic [FIFO_AW:0] wp_q, wp_d, rp_q, rp_d, level, free;
  logic             wr_en, rd_en, space_ok;

  logic [EP_AW-1:0] cnt_q, cnt_d, clen_q, clen_d, eff_m1;
  logic             commit_q, commit_d;
  logic [FT_W-1:0]  ftmr_q, ftmr_d;
  logic [AT_W-1:0]  atmr_q, atmr_d;
  logic             ack_s1_q, ack_s2_q, ack_s3_q, ack_rise;

  logic [15:0] drop_q, drop_d, serr_q, serr_d, miss_q, miss_d, cc_q, cc_d;
  logic        drop_inc, serr_inc, miss_inc, cc_inc;

  // In HUNT the select is live; otherwise the source latched at the last
  // packet boundary is used so a mid-packet sel change waits for the boundary.
  always_comb begin
    src_idx = (ist_q == I_HUNT) ? sel : src_q;
    in_byte = '0;
    in_vld  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_idx == SEL_W'(i)) begin
        in_byte = src_data[8*i +: 8];
        in_vld  = src_valid[i];
      end
    end
  end

  assign level           = wp_q - rp_q;
  assign free            = DEPTH_V - level;
  assign space_ok        = (free >= PKT_V);
  assign src_almost_full = ~space_ok;
  assign fifo_level      = level;

  // Ingress. bc==0 outside HUNT marks "next byte must be a sync byte"; that
  // byte is run through the same admission check HUNT uses.
  always_comb begin
    ist_d    = ist_q;
    bc_d     = bc_q;
    src_d    = src_q;
    wr_en    = 1'b0;
    drop_inc = 1'b0;
    serr_inc = 1'b0;
    if (ist_q == I_HUNT) src_d = sel;
    if (in_vld) begin
      if (ist_q == I_HUNT || bc_q == 8'd0) begin
        if (in_byte == SYNC) begin
          bc_d = 8'd1;
          if (space_ok) begin
            wr_en = 1'b1;
            ist_d = I_PASS;
          end else begin
            ist_d    = I_DROP;
            drop_inc = 1'b1;
          end
        end else if (ist_q != I_HUNT) begin
          serr_inc = 1'b1;
          ist_d    = I_HUNT;
          bc_d     = 8'd0;
        end
      end else begin
        wr_en = (ist_q == I_PASS);
        if (bc_q == BC_LAST) begin
          bc_d  = 8'd0;
          src_d = sel;
        end else begin
          bc_d = bc_q + 8'd1;
        end
      end
    end
  end

  assign wp_d = wp_q + (FIFO_AW+1)'(wr_en);
  assign rp_d = rp_q + (FIFO_AW+1)'(rd_en);

  // Storage is not reset; emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q[FIFO_AW-1:0]] <= in_byte;
    if (rd_en) rdata_q <= mem[rp_q[FIFO_AW-1:0]];
  end

  assign eff_m1   = (commit_len == '0) ? '0 : commit_len - EP_AW'(1);
  assign ack_rise = ack_s2_q & ~ack_s3_q;

  // Egress
  always_comb begin
    est_d    = est_q;
    cnt_d    = cnt_q;
    clen_d   = clen_q;
    commit_d = commit_q;
    ftmr_d   = ftmr_q;
    atmr_d   = atmr_q;
    rd_en    = 1'b0;
    cc_inc   = 1'b0;
    miss_inc = 1'b0;
    ep_wren  = 1'b0;
    ep_addr  = '0;
    ep_data  = '0;
    unique case (est_q)
      E_IDLE: begin
        if (level != '0 && ep_ready) begin
          rd_en  = 1'b1;
          ftmr_d = '0;
          est_d  = E_READ;
        end else if (flush_en && cnt_q != '0 && ftmr_q == FT_MAX) begin
          clen_d   = cnt_q;
          commit_d = 1'b1;
          ftmr_d   = '0;
          atmr_d   = '0;
          est_d    = E_WAIT;
        end else if (level == '0 && cnt_q != '0 && ftmr_q != FT_MAX) begin
          ftmr_d = ftmr_q + FT_W'(1);
        end
      end
      E_READ: est_d = E_WRITE;
      E_WRITE: begin
        ep_wren = 1'b1;
        ep_addr = cnt_q;
        ep_data = rdata_q;
        // >= rather than == so a commit_len lowered below cnt commits at once.
        if (cnt_q >= eff_m1) begin
          clen_d   = cnt_q + EP_AW'(1);
          commit_d = 1'b1;
          ftmr_d   = '0;
          atmr_d   = '0;
          est_d    = E_WAIT;
        end else begin
          cnt_d = cnt_q + EP_AW'(1);
          est_d = E_IDLE;
        end
      end
      E_WAIT: begin
        if (ack_rise || atmr_q == AT_MAX) begin
          commit_d = 1'b0;
          cnt_d    = '0;
          cc_inc   = 1'b1;
          miss_inc = ~ack_rise;
          ftmr_d   = '0;
          est_d    = E_IDLE;
        end else begin
          atmr_d = atmr_q + AT_W'(1);
        end
      end
      default: est_d = E_IDLE;
    endcase
  end

  always_comb begin
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    serr_d = (serr_inc && serr_q != 16'hFFFF) ? serr_q + 16'd1 : serr_q;
    miss_d = (miss_inc && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
    cc_d   = (cc_inc   && cc_q   != 16'hFFFF) ? cc_q   + 16'd1 : cc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ist_q    <= I_HUNT;
      est_q    <= E_IDLE;
      src_q    <= '0;
      bc_q     <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      clen_q   <= '0;
      commit_q <= 1'b0;
      ftmr_q   <= '0;
      atmr_q   <= '0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      ack_s3_q <= 1'b0;
      drop_q   <= '0;
      serr_q   <= '0;
      miss_q   <= '0;
      cc_q     <= '0;
    end else begin
      ist_q    <= ist_d;
      est_q    <= est_d;
      src_q    <= src_d;
      bc_q     <= bc_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      clen_q   <= clen_d;
      commit_q <= commit_d;
      ftmr_q   <= ftmr_d;
      atmr_q   <= atmr_d;
      ack_s1_q <= ep_commit_ack;
      ack_s2_q <= ack_s1_q;
      ack_s3_q <= ack_s2_q;
      drop_q   <= drop_d;
      serr_q   <= serr_d;
      miss_q   <= miss_d;
      cc_q     <= cc_d;
    end
  end

  assign ep_commit     = commit_q;
  assign ep_commit_len = clen_q;
  assign drop_cnt      = drop_q;
  assign sync_err_cnt  = serr_q;
  assign ack_miss_cnt  = miss_q;
  assign commit_cnt    = cc_q;

endmodule

// File: tb/tb_ts_ep_packer.sv
// Directed bench for ts_ep_packer: packet streaming, sync recovery, full-FIFO
// drops, flush, ack timeout, source switch and mid-packet reset.
module tb_ts_ep_packer;
  localparam int NSRC = 4, SEL_W = 2, FIFO_AW = 10, EP_AW = 11;
  localparam int ACK_TMO = 64, FLUSH_TMO = 100;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [SEL_W-1:0]     sel;
  logic [NSRC*8-1:0]    src_data;
  logic [NSRC-1:0]      src_valid;
  logic [EP_AW-1:0]     commit_len;
  logic                 flush_en;
  logic                 src_almost_full;
  logic [EP_AW-1:0]     ep_addr;
  logic [7:0]           ep_data;
  logic                 ep_wren;
  logic                 ep_commit;
  logic [EP_AW-1:0]     ep_commit_len;
  logic                 ep_ready;
  logic                 ep_commit_ack;
  logic [15:0]          drop_cnt, sync_err_cnt, ack_miss_cnt, commit_cnt;
  logic [FIFO_AW:0]     fifo_level;

  ts_ep_packer #(.NSRC(NSRC), .SEL_W(SEL_W), .FIFO_AW(FIFO_AW), .EP_AW(EP_AW),
                 .ACK_TMO(ACK_TMO), .FLUSH_TMO(FLUSH_TMO)) dut (
    .clk(clk), .reset(reset), .sel(sel), .src_data(src_data), .src_valid(src_valid),
    .commit_len(commit_len), .flush_en(flush_en), .src_almost_full(src_almost_full),
    .ep_addr(ep_addr), .ep_data(ep_data), .ep_wren(ep_wren), .ep_commit(ep_commit),
    .ep_commit_len(ep_commit_len), .ep_ready(ep_ready), .ep_commit_ack(ep_commit_ack),
    .drop_cnt(drop_cnt), .sync_err_cnt(sync_err_cnt), .ack_miss_cnt(ack_miss_cnt),
    .commit_cnt(commit_cnt), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] expq[$];
  bit ack_auto = 1'b1;

  // monitor statistics, cleared while reset is high
  int cyc = 0, wcnt = 0, nwr = 0, ncommit = 0, data_err = 0, addr_err = 0;
  int hi = 0, last_hi = 0, last_clen = 0, last_wr_t = 0, rise_t = 0;
  bit com_prev = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      wcnt = 0; nwr = 0; ncommit = 0; data_err = 0; addr_err = 0;
      hi = 0; last_hi = 0; last_clen = 0; com_prev = 1'b0;
      expq.delete();
    end else begin
      if (ep_wren) begin
        if (expq.size() == 0) data_err++;
        else begin
          e = expq.pop_front();
          if (ep_data !== e) data_err++;
        end
        if (int'(ep_addr) != wcnt) addr_err++;
        wcnt++; nwr++; last_wr_t = cyc;
      end
      if (ep_commit && !com_prev) begin
        ncommit++; rise_t = cyc; last_clen = int'(ep_commit_len); hi = 0;
      end
      if (ep_commit) hi++;
      if (!ep_commit && com_prev) begin
        wcnt = 0; last_hi = hi;
      end
      com_prev = ep_commit;
    end
  end

  // endpoint side: acknowledge 5 cycles after each commit request
  initial begin
    ep_commit_ack = 1'b0;
    forever begin
      @(posedge ep_commit);
      if (ack_auto) begin
        repeat (5) @(posedge clk);
        #1 ep_commit_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 ep_commit_ack = 1'b0;
      end
    end
  end

  function automatic logic [7:0] pay(input int seed, input int i);
    logic [7:0] b;
    b = 8'(seed * 37 + i * 3);
    if (b == 8'h47) b = 8'h48;
    return b;
  endfunction

  task automatic put(input int s, input logic [7:0] b, input bit noise);
    src_data = '0;
    src_valid = '0;
    src_data[s*8 +: 8] = b;
    src_valid[s] = 1'b1;
    if (noise) begin
      src_data[15:8] = 8'h11;
      src_valid[1] = 1'b1;
    end
    @(posedge clk); #1;
    src_valid = '0;
  endtask

  task automatic send_pkt(input int s, input logic [7:0] sync, input int seed,
                          input int gap, input bit keep);
    logic [7:0] b;
    for (int i = 0; i < 188; i++) begin
      b = (i == 0) ? sync : pay(seed, i);
      if (keep) expq.push_back(b);
      put(s, b, 1'b0);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int st, n;
    st = 0; n = 0;
    while (st < 80 && n < max) begin
      @(negedge clk); n++;
      if (expq.size() == 0 && !ep_commit && fifo_level == 0) st++;
      else st = 0;
    end
    chk("drain_done", st, 80);
  endtask

  initial begin
    int n;
    reset = 1'b1; sel = '0; src_data = '0; src_valid = '0;
    commit_len = 11'd376; flush_en = 1'b0; ep_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_commit", int'(ep_commit), 0);
    chk("rst_wren", int'(ep_wren), 0);
    chk("rst_clen", int'(ep_commit_len), 0);
    chk("rst_afull", int'(src_almost_full), 0);
    chk("rst_cc", int'(commit_cnt), 0);

    // back-to-back packets, one byte every 4 cycles
    @(posedge clk); #1;
    for (int p = 0; p < 10; p++) send_pkt(0, 8'h47, p + 1, 3, 1'b1);
    wait_idle(20000);
    chk("b2b_commits", ncommit, 5);
    chk("b2b_commit_cnt", int'(commit_cnt), 5);
    chk("b2b_drop", int'(drop_cnt), 0);
    chk("b2b_data_err", data_err, 0);
    chk("b2b_addr_err", addr_err, 0);
    chk("b2b_nwr", nwr, 1880);
    chk("b2b_clen", last_clen, 376);
    chk("b2b_miss", int'(ack_miss_cnt), 0);

    // sync error on second packet
    do_reset();
    send_pkt(0, 8'h47, 20, 0, 1'b1);
    send_pkt(0, 8'h46, 21, 0, 1'b0);
    send_pkt(0, 8'h47, 22, 0, 1'b1);
    wait_idle(5000);
    chk("sync_err", int'(sync_err_cnt), 1);
    chk("sync_nwr", nwr, 376);
    chk("sync_data_err", data_err, 0);
    chk("sync_cc", int'(commit_cnt), 1);

    // FIFO full: 5 admitted, 3 dropped
    do_reset();
    ep_ready = 1'b0;
    for (int p = 0; p < 8; p++) send_pkt(0, 8'h47, 30 + p, 0, p < 5);
    repeat (2) @(negedge clk);
    chk("full_drop", int'(drop_cnt), 3);
    chk("full_level", int'(fifo_level), 940);
    chk("full_afull", int'(src_almost_full), 1);
    chk("full_nwr0", nwr, 0);
    @(posedge clk); #1;
    commit_len = 11'd940; ep_ready = 1'b1;
    wait_idle(8000);
    chk("full_data_err", data_err, 0);
    chk("full_nwr", nwr, 940);
    chk("full_clen", last_clen, 940);
    chk("full_cc", int'(commit_cnt), 1);

    // flush with one packet
    do_reset();
    flush_en = 1'b1; commit_len = 11'd512;
    send_pkt(0, 8'h47, 40, 0, 1'b1);
    n = 0;
    while (ncommit == 0 && n < 3000) begin @(negedge clk); n++; end
    chk("flush_seen", ncommit, 1);
    chk("flush_clen", last_clen, 188);
    chk("flush_delay_ok", int'((rise_t - last_wr_t) >= 95 && (rise_t - last_wr_t) <= 110), 1);
    wait_idle(2000);
    chk("flush_cc", int'(commit_cnt), 1);
    chk("flush_data_err", data_err, 0);

    // no flush
    do_reset();
    flush_en = 1'b0;
    send_pkt(0, 8'h47, 41, 0, 1'b1);
    repeat (800) @(negedge clk);
    chk("noflush_commits", ncommit, 0);
    chk("noflush_cc", int'(commit_cnt), 0);
    chk("noflush_nwr", nwr, 188);

    // ack timeout
    do_reset();
    ack_auto = 1'b0; commit_len = 11'd188;
    send_pkt(0, 8'h47, 50, 0, 1'b1);
    n = 0;
    while (!(ncommit == 1 && !ep_commit) && n < 3000) begin @(negedge clk); n++; end
    chk("tmo_high_len", last_hi, 64);
    chk("tmo_miss", int'(ack_miss_cnt), 1);
    chk("tmo_cc", int'(commit_cnt), 1);
    @(posedge clk); #1;
    ack_auto = 1'b1;
    send_pkt(0, 8'h47, 51, 0, 1'b1);
    wait_idle(3000);
    chk("tmo_addr_err", addr_err, 0);
    chk("tmo_data_err", data_err, 0);
    chk("tmo_nwr", nwr, 376);

    // select change at byte 50; source 1 chatters meanwhile
    do_reset();
    commit_len = 11'd376; sel = 2'd0;
    for (int i = 0; i < 188; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h47 : pay(60, i);
      if (i == 50) sel = 2'd1;
      expq.push_back(b);
      put(0, b, i >= 50);
    end
    send_pkt(1, 8'h47, 61, 0, 1'b1);
    wait_idle(3000);
    chk("sel_data_err", data_err, 0);
    chk("sel_nwr", nwr, 376);
    chk("sel_cc", int'(commit_cnt), 1);
    chk("sel_serr", int'(sync_err_cnt), 0);

    // reset mid-packet with data in the FIFO
    ep_ready = 1'b0;
    for (int i = 0; i < 100; i++) put(1, (i == 0) ? 8'h47 : pay(70, i), 1'b0);
    @(negedge clk);
    chk("mid_level_pre", int'(fifo_level), 100);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_level", int'(fifo_level), 0);
    chk("mid_cc", int'(commit_cnt), 0);
    chk("mid_commit", int'(ep_commit), 0);
    chk("mid_wren", int'(ep_wren), 0);
    chk("mid_afull", int'(src_almost_full), 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
